seq_divider16by8: RTL and testbench
===================================

# seq_divider16by8

Sequential restoring divider that undoes the 8x8 Vedic multiplier's operation: it divides a 16-bit dividend by an 8-bit divisor and returns a 16-bit quotient and an 8-bit remainder. One quotient bit is produced per clock. Each trial subtraction is done by one KSA8BIT instance with the divisor inverted and Cin=1. The block sits beside Vedic_multiplier8bit in the arithmetic datapath and uses a start/busy/done handshake toward its controller.

## Interface
- WIDTH, 8, divisor/remainder width. Dividend and quotient are 2*WIDTH bits. Only 8 is supported while the KSA8BIT subtractor is used.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low, sampled on rising clk.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  2*WIDTH  numerator; captured on the accepted start.
- divisor  input  WIDTH  denominator; captured on the accepted start.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  2*WIDTH  result; held until the next accepted start.
- remainder  output  WIDTH  result; held until the next accepted start.
- div_by_zero  output  1  set with done when the captured divisor == 0; held with the results.

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start=1:
  - capture dividend into the shift register and divisor into its register;
  - clear the partial remainder rem[7:0] and the bit counter cnt;
  - quotient, remainder and div_by_zero are cleared at this edge.
- RUN, each cycle:
  - form shifted = {rem, dividend_msb}, 9 bits, and shift the dividend register left by one;
  - KSA8BIT computes shifted[7:0] + ~divisor + 1, giving diff and carry;
  - ge = shifted[8] | carry;
  - if ge, rem <= diff and the next quotient bit = 1; otherwise rem <= shifted[7:0] and the bit = 0;
  - quotient bits enter at the LSB of the quotient shift register, so the MSB comes first;
  - cnt increments; after 2*WIDTH iterations go to DONE.
- DONE: drive done=1 for one cycle, present the results, then go to IDLE.
- Divisor == 0 is detected at capture:
  - quotient = 16'hFFFF, remainder = dividend[7:0], div_by_zero = 1;
  - this result is identical with or without the macro; only latency differs.
- start while busy or in DONE is ignored; no queueing.
- Operands may change freely after capture.

## Timing
- Reset (rst_n=0 at a rising edge), whatever the state:
  - outputs: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, cnt=0;
  - reset mid-RUN aborts the division with no done pulse.
- start accepted at edge N:
  - busy=1 from N through the edge that enters DONE;
  - done=1 and results valid in the cycle after edge N+2*WIDTH+1, i.e. N+17 for WIDTH=8;
  - busy=0 in that same cycle.
- A new start may be accepted on the first edge after done falls, i.e. while back in IDLE. Back-to-back throughput is one division per 2*WIDTH+2 cycles.
- done is never high for more than one cycle.
- The quotient/remainder/div_by_zero output registers change only at an accepted start (cleared), at DONE entry (loaded) and at reset. They are stable while busy.
- Critical path: one KSA8BIT plus the ge mux per cycle.

## Configuration
- DIVIDER_ZERO_BYPASS_EN:
  - defined: a zero divisor sends IDLE -> DONE directly, skipping RUN. done arrives one cycle after the accepted start (edge N+1), with the zero-divisor result values.
  - undefined: a zero divisor runs the full 2*WIDTH iterations with normal latency. Results are overridden to the same zero-divisor values at DONE entry.

## Test plan
- dividend=10000, divisor=100 -> quotient=100, remainder=0, div_by_zero=0; done exactly 17 cycles after the start edge and busy high throughout.
- dividend=10000, divisor=7 -> quotient=1428, remainder=4. Then dividend=65025, divisor=255 -> quotient=255, remainder=0, issued back-to-back on the first IDLE cycle.
- dividend=65535, divisor=1 -> quotient=65535, remainder=0. Then dividend=5, divisor=200 -> quotient=0, remainder=5.
- dividend=0x0514, divisor=0 -> quotient=0xFFFF, remainder=0x14, div_by_zero=1. Required latency is 1 cycle with DIVIDER_ZERO_BYPASS_EN defined and 17 without.
- start pulsed again, with different operands, 5 cycles into a division of 2400/30 -> ignored; result is quotient=80, remainder=0 at the original timing.
- rst_n=0 for one edge at cycle 8 of a division -> no done pulse, busy=0 and all outputs 0 on the next cycle. A start on the next cycle then divides correctly.

Source files
------------

// File: rtl/seq_divider16by8.sv
// Sequential restoring divider: 16-bit dividend / 8-bit divisor, one quotient bit per clock.
// Optional macro DIVIDER_ZERO_BYPASS_EN: a zero divisor skips the iterations and finishes in one cycle.

module KSA8BIT (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   // Kogge-Stone prefix tree; carry-in is folded into bit 0's generate term
   logic [3:0][7:0] gl;
   logic [2:0][7:0] pl;

   assign pl[0] = a ^ b;
   assign gl[0] = {a[7:1] & b[7:1], (a[0] & b[0]) | ((a[0] ^ b[0]) & cin)};

   for (genvar s = 0; s < 3; s++) begin : g_lvl
      for (genvar i = 0; i < 8; i++) begin : g_bit
         if (i >= (1 << s)) begin : g_op
            assign gl[s+1][i] = gl[s][i] | (pl[s][i] & gl[s][i-(1<<s)]);
            if (s < 2) begin : g_p
               assign pl[s+1][i] = pl[s][i] & pl[s][i-(1<<s)];
            end
         end else begin : g_pass
            assign gl[s+1][i] = gl[s][i];
            if (s < 2) begin : g_p
               assign pl[s+1][i] = pl[s][i];
            end
         end
      end
   end

   assign sum  = pl[0] ^ {gl[3][6:0], cin};
   assign cout = gl[3][7];

endmodule

module seq_divider16by8 #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2*WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]     divisor,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]     remainder,
   output logic                 div_by_zero
);

   localparam int CNT_W = $clog2(2 * WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               zero_div;

   // The dividend register doubles as the quotient shift register: each
   // iteration shifts a dividend bit out of the MSB and a quotient bit into the LSB.
   logic [2*WIDTH-1:0] dvd;
   logic [WIDTH-1:0]   dsr;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   zero_rem;

   logic [WIDTH:0]     shifted;
   logic [WIDTH-1:0]   diff;
   logic               carry;
   logic               ge;
   logic [WIDTH-1:0]   rem_next;
   logic               accept;

   assign accept  = (state == IDLE) && start;
   assign shifted = {rem, dvd[2*WIDTH-1]};

   KSA8BIT u_sub (
      .a    (shifted[WIDTH-1:0]),
      .b    (~dsr),
      .cin  (1'b1),
      .sum  (diff),
      .cout (carry)
   );

   assign ge       = shifted[WIDTH] | carry;
   assign rem_next = ge ? diff : shifted[WIDTH-1:0];

   // datapath registers carry no reset; they are always loaded on an accepted start
   always_ff @(posedge clk) begin
      if (accept) begin
         dvd      <= dividend;
         dsr      <= divisor;
         rem      <= '0;
         zero_rem <= dividend[WIDTH-1:0];
      end else if (state == RUN) begin
         dvd <= {dvd[2*WIDTH-2:0], ge};
         rem <= rem_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         zero_div    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy        <= 1'b1;
                  cnt         <= '0;
                  quotient    <= '0;
                  remainder   <= '0;
                  div_by_zero <= 1'b0;
                  zero_div    <= (divisor == '0);
`ifdef DIVIDER_ZERO_BYPASS_EN
                  state       <= (divisor == '0) ? DONE : RUN;
`else
                  state       <= RUN;
`endif
               end
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST) state <= DONE;
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
               // zero divisor overrides whatever the iterations produced
               if (zero_div) begin
                  quotient    <= '1;
                  remainder   <= zero_rem;
                  div_by_zero <= 1'b1;
               end else begin
                  quotient    <= dvd;
                  remainder   <= rem;
                  div_by_zero <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider16by8.sv
// Scoreboard bench for seq_divider16by8: directed divisions, back-to-back, ignored start, zero divisor, mid-run reset.

module tb_seq_divider16by8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] dividend = '0;
   logic [7:0]  divisor = '0;
   logic        busy, done, div_by_zero;
   logic [15:0] quotient;
   logic [7:0]  remainder;

   seq_divider16by8 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

`ifdef DIVIDER_ZERO_BYPASS_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = 17;
`endif

   typedef struct {
      logic [15:0] q;
      logic [7:0]  r;
      logic        dz;
      int          n;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   logic hold_ok = 1'b1;
   logic prev_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // monitor: pops the scoreboard on every done pulse
   always @(negedge clk) begin
      if (rst_n) begin
         if (done) begin
            chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("quotient", {16'd0, quotient}, {16'd0, e.q});
               chk("remainder", {24'd0, remainder}, {24'd0, e.r});
               chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
               chk("latency", cyc - e.n, e.lat);
               chk("busy_at_done", {31'd0, busy}, 32'd0);
               chk("busy_and_hold", {31'd0, hold_ok}, 32'd1);
            end
            hold_ok = 1'b1;
         end else if (sb.size() != 0) begin
            if (!busy || quotient != 16'd0 || remainder != 8'd0 || div_by_zero) hold_ok = 1'b0;
         end
         prev_done = done;
      end else begin
         prev_done = 1'b0;
      end
   end

   // caller is at a falling edge; start is accepted on the next rising edge
   task automatic issue(input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] q, input logic [7:0] r, input logic dz,
                        input int lat, input bit push);
      exp_t e;
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      e.q = q; e.r = r; e.dz = dz; e.n = cyc; e.lat = lat;
      if (push) sb.push_back(e);
      @(negedge clk);
      start    = 1'b0;
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40; i++) begin
         if (done) return;
         @(negedge clk);
      end
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done within 40 cycles, expected a done pulse");
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got simulation still running, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      start = 1'b1;
      dividend = 16'd1234;
      divisor = 8'd5;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_quotient", {16'd0, quotient}, 32'd0);
      chk("rst_remainder", {24'd0, remainder}, 32'd0);
      chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
      start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      issue(16'd10000, 8'd100, 16'd100, 8'd0, 1'b0, 17, 1'b1);
      wait_done();
      @(negedge clk);

      issue(16'd10000, 8'd7, 16'd1428, 8'd4, 1'b0, 17, 1'b1);
      wait_done();
      issue(16'd65025, 8'd255, 16'd255, 8'd0, 1'b0, 17, 1'b1);
      wait_done();
      issue(16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, 17, 1'b1);
      wait_done();
      issue(16'd5, 8'd200, 16'd0, 8'd5, 1'b0, 17, 1'b1);
      wait_done();
      issue(16'h0514, 8'd0, 16'hFFFF, 8'h14, 1'b1, ZLAT, 1'b1);
      wait_done();
      @(negedge clk);

      // a second start mid-division must be ignored
      issue(16'd2400, 8'd30, 16'd80, 8'd0, 1'b0, 17, 1'b1);
      repeat (3) @(negedge clk);
      start = 1'b1;
      dividend = 16'd9999;
      divisor = 8'd3;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      @(negedge clk);

      // reset at cycle 8 of a division aborts it
      issue(16'd40000, 8'd77, 16'd0, 8'd0, 1'b0, 17, 1'b0);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_quotient", {16'd0, quotient}, 32'd0);
      chk("abort_remainder", {24'd0, remainder}, 32'd0);
      chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(16'd1000, 8'd9, 16'd111, 8'd1, 1'b0, 17, 1'b1);
      wait_done();
      repeat (25) @(negedge clk);

      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
